// File: rtl/transport_judge_if.sv
// Bundle of direction requests, downstream busy flags and arbitration results for transport_judge.
// The fail_cnt_* signals exist only when JUDGE_STATS_EN is defined.
interface transport_judge_if #(
  parameter int CNT_W = 8
);
  logic [1:0] dout_x;
  logic [1:0] dout_y;
  logic [1:0] dout_local;
  logic [2:0] busy;
  logic [2:0] fail;
  logic [1:0] grant_x;
  logic [1:0] grant_y;
  logic [1:0] grant_local;
`ifdef JUDGE_STATS_EN
  logic [CNT_W-1:0] fail_cnt_x;
  logic [CNT_W-1:0] fail_cnt_y;
  logic [CNT_W-1:0] fail_cnt_local;

  modport master (
    output dout_x, dout_y, dout_local, busy,
    input  fail, grant_x, grant_y, grant_local,
    input  fail_cnt_x, fail_cnt_y, fail_cnt_local
  );
  modport slave (
    input  dout_x, dout_y, dout_local, busy,
    output fail, grant_x, grant_y, grant_local,
    output fail_cnt_x, fail_cnt_y, fail_cnt_local
  );
`else
  modport master (
    output dout_x, dout_y, dout_local, busy,
    input  fail, grant_x, grant_y, grant_local
  );
  modport slave (
    input  dout_x, dout_y, dout_local, busy,
    output fail, grant_x, grant_y, grant_local
  );
`endif
endinterface

// File: rtl/transport_judge.sv
// Per-cycle round-robin output-port arbiter for the 3-port router (X, Y, LOCAL).
// Optional per-input saturating fail counters are built when JUDGE_STATS_EN is defined.
module transport_judge #(
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  input logic               enable,
  transport_judge_if.slave  bus
);

  // Input/output codes: 01 = X, 10 = Y, 11 = LOCAL; fail bit of input code c sits at bit (3 - c).
  typedef struct packed {
    logic [2:0] fail_mask;
    logic [1:0] grant;
    logic [1:0] ptr;
  } arb_t;

  function automatic logic [2:0] code_mask(input logic [1:0] code);
    logic [2:0] m;
    case (code)
      2'b01:   m = 3'b100;
      2'b10:   m = 3'b010;
      2'b11:   m = 3'b001;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] pick_winner(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] win;
    idx = ptr;
    win = 2'b00;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'b11) ? 2'b01 : idx + 2'b01;
      if (win == 2'b00 && (req & code_mask(idx)) != 3'b000) begin
        win = idx;
      end else begin
        win = win;
      end
    end
    return win;
  endfunction

  function automatic arb_t arbitrate(input logic [2:0] req, input logic busy, input logic [1:0] ptr);
    arb_t r;
    logic [1:0] win;
    r.fail_mask = 3'b000;
    r.grant     = 2'b00;
    r.ptr       = ptr;
    if (req == 3'b000) begin
      r.fail_mask = 3'b000;
    end else if (busy) begin
      r.fail_mask = req;
    end else begin
      win         = pick_winner(req, ptr);
      r.grant     = win;
      r.ptr       = win;
      r.fail_mask = req & ~code_mask(win);
    end
    return r;
  endfunction

  // Index o of the per-output arrays: 0 = X, 1 = Y, 2 = LOCAL.
  logic [2:0][2:0] req_s;
  logic [2:0]      busy_s;
  arb_t [2:0]      arb_s;
  logic [2:0][1:0] grant_d;
  logic [2:0][1:0] ptr_d;
  logic [2:0]      fail_d;
  logic [2:0][1:0] grant_q;
  logic [2:0][1:0] ptr_q;
  logic [2:0]      fail_q;

  assign busy_s = {bus.busy[0], bus.busy[1], bus.busy[2]};

  for (genvar o = 0; o < 3; o++) begin : g_out
    localparam logic [1:0] CODE = 2'(o + 1);
    assign req_s[o]   = {bus.dout_x == CODE, bus.dout_y == CODE, bus.dout_local == CODE};
    assign arb_s[o]   = arbitrate(req_s[o], busy_s[o], ptr_q[o]);
    assign grant_d[o] = arb_s[o].grant;
    assign ptr_d[o]   = arb_s[o].ptr;
  end

  // Each input requests at most one output, so the masks never overlap.
  assign fail_d = arb_s[0].fail_mask | arb_s[1].fail_mask | arb_s[2].fail_mask;

  // Arbitration result and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q  <= 3'b000;
      grant_q <= {2'b00, 2'b00, 2'b00};
      ptr_q   <= {2'b11, 2'b11, 2'b11};
    end else if (enable) begin
      fail_q  <= fail_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end else begin
      fail_q  <= fail_q;
      grant_q <= grant_q;
      ptr_q   <= ptr_q;
    end
  end

  assign bus.fail        = fail_q;
  assign bus.grant_x     = grant_q[0];
  assign bus.grant_y     = grant_q[1];
  assign bus.grant_local = grant_q[2];

`ifdef JUDGE_STATS_EN
  logic [2:0][CNT_W-1:0] cnt_q;
  logic [2:0][CNT_W-1:0] cnt_d;

  // Saturating increment of each input's counter when its new fail bit is set.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (fail_d[i] && cnt_q[i] != {CNT_W{1'b1}}) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Fail counter registers, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_d;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign bus.fail_cnt_x     = cnt_q[2];
  assign bus.fail_cnt_y     = cnt_q[1];
  assign bus.fail_cnt_local = cnt_q[0];
`endif

endmodule

// File: tb/tb_transport_judge.sv
// Scoreboard bench for transport_judge: a queue-based reference model predicts every cycle's outputs.
module tb_transport_judge;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;

  always #5 clk = ~clk;

  transport_judge_if #(.CNT_W(CNT_W)) bus ();
  transport_judge #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus));

  typedef struct packed {
    logic [2:0]            fail;
    logic [1:0]            gx;
    logic [1:0]            gy;
    logic [1:0]            gl;
    logic [2:0][CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   ptr[3];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    ptr = '{2, 2, 2};
    cur = '0;
  endfunction

  // Model: inputs/outputs indexed 0=X,1=Y,2=LOCAL; pointer holds index of last winner.
  function automatic void model_step(input logic [1:0] d0, input logic [1:0] d1,
                                     input logic [1:0] d2, input logic [2:0] b);
    int   d[3];
    int   g[3];
    exp_t nx;
    d = '{int'(d0), int'(d1), int'(d2)};
    g = '{0, 0, 0};
    nx = cur;
    nx.fail = 3'b000;
    for (int o = 0; o < 3; o++) begin
      int w;
      w = -1;
      if (b[2-o]) begin
        for (int i = 0; i < 3; i++) if (d[i] == o + 1) nx.fail[2-i] = 1'b1;
      end else begin
        for (int k = 1; k <= 3; k++) begin
          int i;
          i = (ptr[o] + k) % 3;
          if (w < 0 && d[i] == o + 1) w = i;
        end
        if (w >= 0) begin
          ptr[o] = w;
          g[o] = w + 1;
          for (int i = 0; i < 3; i++) if (d[i] == o + 1 && i != w) nx.fail[2-i] = 1'b1;
        end
      end
    end
    nx.gx = 2'(g[0]);
    nx.gy = 2'(g[1]);
    nx.gl = 2'(g[2]);
    for (int i = 0; i < 3; i++) begin
      if (nx.fail[i] && int'(cur.cnt[i]) < (1 << CNT_W) - 1) nx.cnt[i] = cur.cnt[i] + 1'b1;
    end
    cur = nx;
  endfunction

  task automatic step(input logic en, input logic [1:0] dx, input logic [1:0] dy,
                      input logic [1:0] dl, input logic [2:0] b);
    @(negedge clk);
    enable = en;
    bus.dout_x = dx;
    bus.dout_y = dy;
    bus.dout_local = dl;
    bus.busy = b;
    @(posedge clk);
    if (en) model_step(dx, dy, dl, b);
    q.push_back(cur);
  endtask

  // Asynchronous reset assertion; outputs must clear without a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_fail", 32'(bus.fail), 32'd0);
    chk("rst_grant_x", 32'(bus.grant_x), 32'd0);
    chk("rst_grant_y", 32'(bus.grant_y), 32'd0);
    chk("rst_grant_local", 32'(bus.grant_local), 32'd0);
`ifdef JUDGE_STATS_EN
    chk("rst_cnt_x", 32'(bus.fail_cnt_x), 32'd0);
`endif
    q.delete();
    model_reset();
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare one predicted cycle at each falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("fail", 32'(bus.fail), 32'(e.fail));
      chk("grant_x", 32'(bus.grant_x), 32'(e.gx));
      chk("grant_y", 32'(bus.grant_y), 32'(e.gy));
      chk("grant_local", 32'(bus.grant_local), 32'(e.gl));
`ifdef JUDGE_STATS_EN
      chk("fail_cnt_x", 32'(bus.fail_cnt_x), 32'(e.cnt[2]));
      chk("fail_cnt_y", 32'(bus.fail_cnt_y), 32'(e.cnt[1]));
      chk("fail_cnt_local", 32'(bus.fail_cnt_local), 32'(e.cnt[0]));
`endif
    end
  end

  initial begin
    bus.dout_x = 2'b00;
    bus.dout_y = 2'b00;
    bus.dout_local = 2'b00;
    bus.busy = 3'b000;
    #2;
    do_reset();

    // Crossed requests, no conflicts.
    step(1'b1, 2'b10, 2'b01, 2'b11, 3'b000);

    // Three-way contention for Y rotates X -> Y -> LOCAL, then async reset while fail=110.
    do_reset();
    repeat (3) step(1'b1, 2'b10, 2'b10, 2'b10, 3'b000);
    #2;
    chk("pre_rst_fail", 32'(bus.fail), 32'(3'b110));
    do_reset();

    // Busy output rejects all requesters and leaves the pointer alone.
    step(1'b1, 2'b01, 2'b00, 2'b01, 3'b100);
    step(1'b1, 2'b01, 2'b00, 2'b01, 3'b000);

    // Enable low holds everything, including the pointer.
    repeat (4) step(1'b0, 2'b01, 2'b01, 2'b01, 3'b000);
    step(1'b1, 2'b01, 2'b01, 2'b01, 3'b000);

    // X-in loses five times in a row (counter saturation when stats are built).
    do_reset();
    repeat (5) step(1'b1, 2'b01, 2'b00, 2'b00, 3'b100);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
    end

    @(negedge clk);
    #1;
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
